// File: rtl/register_file_pkg.sv
// Shared rv32i integer register-file constants and types.
// Imported by the register file and by anything that indexes it.
package register_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam int ZERO_REG   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic signed [XLEN-1:0] word_t;

endpackage

// File: rtl/register_file.sv
// rv32i integer register file: two combinational read ports, one synchronous write port.
// Register x0 is hardwired to zero; write-back has no bypass into the read ports.
module register_file
    import register_file_pkg::*;
#(
    parameter int DataWidth = XLEN,
    parameter int AddrWidth = REG_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic        [AddrWidth-1:0] rs1,
    output logic signed [DataWidth-1:0] rs1_data_out,
    input  logic        [AddrWidth-1:0] rs2,
    output logic signed [DataWidth-1:0] rs2_data_out,
    input  logic        [AddrWidth-1:0] rd,
    input  logic                        rd_write_enable,
    input  logic        [DataWidth-1:0] rd_data_in
);

    localparam int Depth = 1 << AddrWidth;
    localparam logic [AddrWidth-1:0] ZeroIdx = AddrWidth'(ZERO_REG);

    // Flop array rather than RAM so that reset can clear every entry in one edge.
    logic signed [DataWidth-1:0] mem_q [Depth];

    logic wr_en_d;
    assign wr_en_d = rd_write_enable && (rd != ZeroIdx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[rd] <= $signed(rd_data_in);
        end
    end

    // x0 is forced at the read mux so it reads zero regardless of storage contents.
    assign rs1_data_out = (rs1 == ZeroIdx) ? '0 : mem_q[rs1];
    assign rs2_data_out = (rs2 == ZeroIdx) ? '0 : mem_q[rs2];

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file with a queue-based scoreboard.
// Expected read data comes from a bench-side model of the register contents.
module tb_register_file;

    logic               clk;
    logic               rst_n;
    logic        [4:0]  rs1;
    logic signed [31:0] rs1_data_out;
    logic        [4:0]  rs2;
    logic signed [31:0] rs2_data_out;
    logic        [4:0]  rd;
    logic               rd_write_enable;
    logic        [31:0] rd_data_in;

    register_file #(
        .DataWidth(32),
        .AddrWidth(5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs1            (rs1),
        .rs1_data_out   (rs1_data_out),
        .rs2            (rs2),
        .rs2_data_out   (rs2_data_out),
        .rd             (rd),
        .rd_write_enable(rd_write_enable),
        .rd_data_in     (rd_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int passed;
    int total;

    // One rising edge; the model follows the architectural write rule.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (rd_write_enable && rd != 5'd0) begin
            model[rd] = rd_data_in;
        end
        #1;
    endtask

    // Present both read indices, push expected values, then pop and compare.
    task automatic check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] o1;
        logic [31:0] o2;
        rs1 = a1;
        rs2 = a2;
        exp_q.push_back(model[a1]);
        exp_q.push_back(model[a2]);
        #1;
        o1 = rs1_data_out;
        o2 = rs2_data_out;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        total++;
        assert (o1 === e1) passed++;
        else $error("FAIL %s rs1[%0d] got %h expected %h", tag, a1, o1, e1);
        total++;
        assert (o2 === e2) passed++;
        else $error("FAIL %s rs2[%0d] got %h expected %h", tag, a2, o2, e2);
    endtask

    task automatic check_const(input string tag, input logic [4:0] a1, input logic [31:0] want);
        logic [31:0] o1;
        rs1 = a1;
        exp_q.push_back(want);
        #1;
        o1 = rs1_data_out;
        total++;
        assert (o1 === exp_q[0]) passed++;
        else $error("FAIL %s rs1[%0d] got %h expected %h", tag, a1, o1, exp_q[0]);
        void'(exp_q.pop_front());
    endtask

    task automatic write(input logic [4:0] idx, input logic [31:0] data);
        rd = idx;
        rd_data_in = data;
        rd_write_enable = 1'b1;
        tick();
        rd_write_enable = 1'b0;
    endtask

    initial begin
        passed = 0;
        total = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;
        rst_n = 1'b0;
        rs1 = '0;
        rs2 = '0;
        rd = '0;
        rd_write_enable = 1'b0;
        rd_data_in = '0;

        // Reset, then sweep all indices on both ports.
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("reset_sweep", 5'(i), 5'(31 - i));
            check_const("reset_zero", 5'(i), 32'h0);
        end

        // Write x5; in the write cycle the old value is still read.
        rd = 5'd5;
        rd_data_in = 32'hDEADBEEF;
        rd_write_enable = 1'b1;
        check_const("rdw_old", 5'd5, 32'h0);
        tick();
        rd_write_enable = 1'b0;
        check("x5_both", 5'd5, 5'd5);
        check_const("x5_val", 5'd5, 32'hDEADBEEF);

        // x0 write is a no-op.
        write(5'd0, 32'h12345678);
        check("x0_write", 5'd0, 5'd5);
        check_const("x0_zero", 5'd0, 32'h0);

        write(5'd1, 32'h00000001);
        write(5'd31, 32'hFFFFFFFF);
        write(5'd16, 32'h80000000);
        check("x31_x16", 5'd31, 5'd16);
        check_const("x31_val", 5'd31, 32'hFFFFFFFF);
        check_const("x16_val", 5'd16, 32'h80000000);
        check_const("x1_val", 5'd1, 32'h00000001);

        // Enable low: no write over several edges, then two-cycle write.
        rd = 5'd7;
        rd_data_in = 32'hAAAA5555;
        rd_write_enable = 1'b0;
        tick();
        tick();
        tick();
        check_const("x7_noen", 5'd7, 32'h0);
        rd_write_enable = 1'b1;
        tick();
        tick();
        rd_write_enable = 1'b0;
        check_const("x7_twice", 5'd7, 32'hAAAA5555);
        check("x7_x5", 5'd7, 5'd5);

        // Reset mid-operation clears everything and drops the concurrent write.
        write(5'd10, 32'hCAFEBABE);
        check_const("x10_val", 5'd10, 32'hCAFEBABE);
        rst_n = 1'b0;
        rd = 5'd12;
        rd_data_in = 32'h11111111;
        rd_write_enable = 1'b1;
        tick();
        rst_n = 1'b1;
        rd_write_enable = 1'b0;
        check_const("x10_rst", 5'd10, 32'h0);
        check_const("x12_rst", 5'd12, 32'h0);
        check_const("x5_rst", 5'd5, 32'h0);
        for (int i = 0; i < 32; i++) check("post_rst_sweep", 5'(i), 5'(i ^ 5'h1F));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
